// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate divider plus horizontal/vertical position counters.
// Drives the coord_x/coord_y/active_area bus for the graphics stage and
// hsync/vsync for the VGA connector. Every output is a register decoded
// from the counter values one clk earlier, so all outputs stay mutually aligned.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   output logic       pixel_tick,
   output logic [9:0] coord_x,
   output logic [9:0] coord_y,
   output logic       active_area,
   output logic       hsync,
   output logic       vsync,
   output logic       line_start,
   output logic       frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       H_MAX   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_MAX   = 10'(V_TOTAL - 1);

   // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
   localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
   localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

   if (CLK_DIV < 1 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_cfg
      $error("vga_timing_gen: CLK_DIV must be >=1 and H_TOTAL/V_TOTAL <= 1024");
   end

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic             div_wrap, h_wrap;

   logic       pixel_tick_q, pixel_tick_d;
   logic [9:0] coord_x_q, coord_x_d;
   logic [9:0] coord_y_q, coord_y_d;
   logic       active_area_q, active_area_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;

   logic [10:0] h_ext, v_ext;

   // next-state of the cascaded div -> h -> v counters
   always_comb begin
      div_wrap = (div_q == DIV_MAX);
      h_wrap   = (h_q == H_MAX);
      div_d    = div_wrap ? '0 : div_q + 1'b1;
      h_d      = h_q;
      v_d      = v_q;
      if (div_wrap) begin
         h_d = h_wrap ? '0 : h_q + 1'b1;
         if (h_wrap) begin
            v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
         end
      end
   end

   // counter registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   // decode outputs from the present counter values
   always_comb begin
      h_ext         = {1'b0, h_q};
      v_ext         = {1'b0, v_q};
      pixel_tick_d  = div_wrap;
      coord_x_d     = h_q;
      coord_y_d     = v_q;
      active_area_d = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
      hsync_d       = ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (div_q == '0) && (h_q == '0);
      frame_start_d = (div_q == '0) && (h_q == '0) && (v_q == '0);
   end

   // output registers: one clk behind the counters, syncs idle while in reset
   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_tick_q  <= 1'b0;
         coord_x_q     <= '0;
         coord_y_q     <= '0;
         active_area_q <= 1'b0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         pixel_tick_q  <= pixel_tick_d;
         coord_x_q     <= coord_x_d;
         coord_y_q     <= coord_y_d;
         active_area_q <= active_area_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pixel_tick  = pixel_tick_q;
   assign coord_x     = coord_x_q;
   assign coord_y     = coord_y_q;
   assign active_area = active_area_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a tiny active-high
// configuration, CLK_DIV=3, and a shortened-vertical configuration.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;

   logic       a_tick, a_act, a_hs, a_vs, a_ls, a_fs;
   logic [9:0] a_x, a_y;
   logic       b_tick, b_act, b_hs, b_vs, b_ls, b_fs;
   logic [9:0] b_x, b_y;
   logic       c_tick, c_act, c_hs, c_vs, c_ls, c_fs;
   logic [9:0] c_x, c_y;
   logic       d_tick, d_act, d_hs, d_vs, d_ls, d_fs;
   logic [9:0] d_x, d_y;

   // defaults: 640x480, CLK_DIV=2
   vga_timing_gen u_a (
      .clk(clk), .reset(rst_a), .pixel_tick(a_tick), .coord_x(a_x), .coord_y(a_y),
      .active_area(a_act), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs)
   );

   // tiny: 8 x 6 totals, CLK_DIV=1, active-high syncs
   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
   ) u_b (
      .clk(clk), .reset(rst_b), .pixel_tick(b_tick), .coord_x(b_x), .coord_y(b_y),
      .active_area(b_act), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs)
   );

   // defaults with CLK_DIV=3
   vga_timing_gen #(.CLK_DIV(3)) u_c (
      .clk(clk), .reset(rst_c), .pixel_tick(c_tick), .coord_x(c_x), .coord_y(c_y),
      .active_area(c_act), .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs)
   );

   // short frame: H 16/2/4/2 (24), V 8/2/2/3 (15), CLK_DIV=2 -> 48 clk lines, 720 clk frames
   vga_timing_gen #(
      .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
   ) u_d (
      .clk(clk), .reset(rst_d), .pixel_tick(d_tick), .coord_x(d_x), .coord_y(d_y),
      .active_area(d_act), .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   int unsigned k, xe, ye;
   int unsigned act_fall, act_fall_x, hs_fall, hs_fall_x, hs_rise, hs_rise_x;
   int unsigned ls_n, found;
   int unsigned ls_t[2], ls_x[2], ls_y[2], ls_px[2];
   int unsigned vs_fall, vs_fall_y, vs_rise, vs_rise_y, vs_low, act_bad, ls_cnt, fs_n;
   int unsigned fs_t[3], fs_px, fs_py;
   logic        p_act, p_hs, p_vs;
   logic [9:0]  p_x, p_y;

   initial begin
      // ---------------- reset values ----------------
      repeat (5) @(negedge clk);
      chk("a_rst_x",    32'(a_x), 0);
      chk("a_rst_y",    32'(a_y), 0);
      chk("a_rst_act",  32'(a_act), 0);
      chk("a_rst_hs",   32'(a_hs), 1);
      chk("a_rst_vs",   32'(a_vs), 1);
      chk("a_rst_tick", 32'(a_tick), 0);
      chk("a_rst_ls",   32'(a_ls), 0);
      chk("a_rst_fs",   32'(a_fs), 0);
      chk("b_rst_hs",   32'(b_hs), 0);
      chk("b_rst_vs",   32'(b_vs), 0);
      chk("b_rst_tick", 32'(b_tick), 0);

      // ---------------- defaults: release ----------------
      rst_a = 1'b0;
      @(negedge clk); // t=1
      chk("a_rel_x",    32'(a_x), 0);
      chk("a_rel_y",    32'(a_y), 0);
      chk("a_rel_act",  32'(a_act), 1);
      chk("a_rel_ls",   32'(a_ls), 1);
      chk("a_rel_fs",   32'(a_fs), 1);
      chk("a_rel_tick", 32'(a_tick), 0);
      chk("a_rel_hs",   32'(a_hs), 1);
      chk("a_rel_vs",   32'(a_vs), 1);
      @(negedge clk); // t=2
      chk("a_t2_tick", 32'(a_tick), 1);
      chk("a_t2_ls",   32'(a_ls), 0);
      chk("a_t2_fs",   32'(a_fs), 0);
      chk("a_t2_x",    32'(a_x), 0);
      @(negedge clk); // t=3
      chk("a_t3_x",    32'(a_x), 1);
      chk("a_t3_tick", 32'(a_tick), 0);

      // ---------------- defaults: horizontal timing ----------------
      act_fall = 0; hs_fall = 0; hs_rise = 0; ls_n = 0;
      act_fall_x = 0; hs_fall_x = 0; hs_rise_x = 0;
      p_act = a_act; p_hs = a_hs; p_x = a_x;
      for (int unsigned t = 4; t <= 3300; t++) begin
         @(negedge clk);
         if (p_act && !a_act && act_fall == 0) begin act_fall = t; act_fall_x = 32'(a_x); end
         if (p_hs && !a_hs && hs_fall == 0) begin hs_fall = t; hs_fall_x = 32'(a_x); end
         if (!p_hs && a_hs && hs_rise == 0) begin hs_rise = t; hs_rise_x = 32'(a_x); end
         if (a_ls && ls_n < 2) begin
            ls_t[ls_n] = t; ls_x[ls_n] = 32'(a_x); ls_y[ls_n] = 32'(a_y); ls_px[ls_n] = 32'(p_x);
            ls_n++;
         end
         p_act = a_act; p_hs = a_hs; p_x = a_x;
      end
      chk("a_act_fall_t", act_fall, 1281);
      chk("a_act_fall_x", act_fall_x, 640);
      chk("a_hs_fall_t",  hs_fall, 1313);
      chk("a_hs_fall_x",  hs_fall_x, 656);
      chk("a_hs_rise_x",  hs_rise_x, 752);
      chk("a_hs_low_len", hs_rise - hs_fall, 192);
      chk("a_ls_n",       ls_n, 2);
      chk("a_ls1_t",      ls_t[0], 1601);
      chk("a_ls1_x",      ls_x[0], 0);
      chk("a_ls1_y",      ls_y[0], 1);
      chk("a_ls1_prev_x", ls_px[0], 799);
      chk("a_ls_period",  ls_t[1] - ls_t[0], 1600);
      chk("a_ls2_y",      ls_y[1], 2);

      // ---------------- defaults: reset mid-frame at (300,2) ----------------
      found = 0;
      for (int unsigned i = 0; i < 1200 && found == 0; i++) begin
         @(negedge clk);
         if (a_x == 10'd300 && a_y == 10'd2) found = 1;
      end
      chk("a_mid_seek", found, 1);
      rst_a = 1'b1;
      @(negedge clk);
      chk("a_mid_x",    32'(a_x), 0);
      chk("a_mid_y",    32'(a_y), 0);
      chk("a_mid_act",  32'(a_act), 0);
      chk("a_mid_hs",   32'(a_hs), 1);
      chk("a_mid_ls",   32'(a_ls), 0);
      chk("a_mid_tick", 32'(a_tick), 0);
      rst_a = 1'b0;
      @(negedge clk);
      chk("a_re_x",   32'(a_x), 0);
      chk("a_re_y",   32'(a_y), 0);
      chk("a_re_act", 32'(a_act), 1);
      chk("a_re_fs",  32'(a_fs), 1);
      rst_a = 1'b1;

      // ---------------- tiny config, CLK_DIV=1, active-high ----------------
      rst_b = 1'b0;
      for (int unsigned t = 1; t <= 100; t++) begin
         @(negedge clk);
         k  = t - 1;
         xe = k % 8;
         ye = (k / 8) % 6;
         chk("b_tick", 32'(b_tick), 1);
         chk("b_x",    32'(b_x), xe);
         chk("b_y",    32'(b_y), ye);
         chk("b_hs",   32'(b_hs), 32'(xe == 5 || xe == 6));
         chk("b_vs",   32'(b_vs), 32'(ye == 4));
         chk("b_act",  32'(b_act), 32'(xe < 4 && ye < 3));
         chk("b_fs",   32'(b_fs), 32'(k % 48 == 0));
      end
      rst_b = 1'b1;

      // ---------------- CLK_DIV=3 defaults ----------------
      rst_c = 1'b0;
      for (int unsigned t = 1; t <= 2500; t++) begin
         @(negedge clk);
         k = t - 1;
         chk("c_tick", 32'(c_tick), 32'(k % 3 == 2));
         chk("c_x",    32'(c_x), (k / 3) % 800);
         chk("c_y",    32'(c_y), k / 2400);
         chk("c_ls",   32'(c_ls), 32'(k % 2400 == 0));
      end
      rst_c = 1'b1;

      // ---------------- short frame: vertical timing ----------------
      rst_d = 1'b0;
      vs_fall = 0; vs_rise = 0; vs_fall_y = 0; vs_rise_y = 0;
      vs_low = 0; act_bad = 0; ls_cnt = 0; fs_n = 0; fs_px = 0; fs_py = 0;
      p_vs = 1'b1; p_x = '0; p_y = '0;
      for (int unsigned t = 1; t <= 1500; t++) begin
         @(negedge clk);
         if (d_y >= 10'd8 && d_act) act_bad++;
         if (t <= 720) begin
            if (!d_vs) vs_low++;
            if (d_ls) ls_cnt++;
         end
         if (p_vs && !d_vs && vs_fall == 0) begin vs_fall = t; vs_fall_y = 32'(d_y); end
         if (!p_vs && d_vs && vs_rise == 0) begin vs_rise = t; vs_rise_y = 32'(d_y); end
         if (d_fs && fs_n < 3) begin
            fs_t[fs_n] = t;
            if (fs_n == 1) begin fs_px = 32'(p_x); fs_py = 32'(p_y); end
            fs_n++;
         end
         p_vs = d_vs; p_x = d_x; p_y = d_y;
      end
      chk("d_act_blank",  act_bad, 0);
      chk("d_vs_low_len", vs_low, 96);
      chk("d_vs_fall_t",  vs_fall, 481);
      chk("d_vs_fall_y",  vs_fall_y, 10);
      chk("d_vs_rise_y",  vs_rise_y, 12);
      chk("d_vs_span",    vs_rise - vs_fall, 96);
      chk("d_fs_n",       fs_n, 3);
      chk("d_fs1_t",      fs_t[0], 1);
      chk("d_fs_period",  fs_t[1] - fs_t[0], 720);
      chk("d_fs_period2", fs_t[2] - fs_t[1], 720);
      chk("d_fs_prev_x",  fs_px, 23);
      chk("d_fs_prev_y",  fs_py, 14);
      chk("d_ls_per_fr",  ls_cnt, 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
